// File: rtl/ps2_rx_fifo_if.sv
// Host-side bus of the PS/2 receiver: pop handshake, FIFO head/occupancy, sticky flags.
interface ps2_rx_fifo_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              clear;
  logic              rd;
  logic              rda;
  logic [7:0]        data;
  logic [ADDR_W:0]   count;
  logic              parity_err;
  logic              frame_err;
  logic              overflow;

  // Register block side: issues clear/rd, observes status.
  modport master (
    output clear, rd,
    input  rda, data, count, parity_err, frame_err, overflow
  );

  // Receiver side.
  modport slave (
    input  clear, rd,
    output rda, data, count, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver on the system clock: pin conditioning, frame FSM,
// show-ahead scancode FIFO with pop handshake and sticky error flags.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kbd_clk,
  input  logic          kbd_data,
  ps2_rx_fifo_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned FLT_W = $clog2(FILTER_LEN);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------- conditioning
  logic [1:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  logic             filt_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             flt_flip_c;
  logic             bit_ev_c;
  logic             bit_c;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], kbd_clk};
      dat_sync_q <= {dat_sync_q[0], kbd_data};
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign flt_flip_c = (clk_sync_q[1] != filt_q) &&
                      (flt_cnt_q == FLT_W'(FILTER_LEN - 1));
  assign bit_ev_c   = flt_flip_c & filt_q;
  assign bit_c      = dat_sync_q[1];

  // Glitch filter on the synchronised PS/2 clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else if (clk_sync_q[1] == filt_q) begin
      flt_cnt_q <= '0;
    end else if (flt_flip_c) begin
      filt_q    <= clk_sync_q[1];
      flt_cnt_q <= '0;
    end else begin
      flt_cnt_q <= flt_cnt_q + FLT_W'(1);
    end
  end

  // ---------------------------------------------------------------- frame FSM
  state_e           state_q, state_n;
  logic [7:0]       shift_q, shift_n;
  logic [2:0]       bit_cnt_q, bit_cnt_n;
  logic             par_q, par_n;
  logic [TMO_W-1:0] tmo_q, tmo_n;
  logic             push_c;
  logic             frame_set_c;
  logic             parity_set_c;

  // Frame state and datapath registers; clear aborts the frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else if (bus.clear) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      bit_cnt_q <= bit_cnt_n;
      par_q     <= par_n;
      tmo_q     <= tmo_n;
    end
  end

  // Next-state: start/data/parity/stop sequencing and inter-bit timeout.
  always_comb begin
    state_n      = state_q;
    shift_n      = shift_q;
    bit_cnt_n    = bit_cnt_q;
    par_n        = par_q;
    tmo_n        = tmo_q;
    push_c       = 1'b0;
    frame_set_c  = 1'b0;
    parity_set_c = 1'b0;

    if (state_q == ST_IDLE) begin
      tmo_n = '0;
      if (bit_ev_c) begin
        if (!bit_c) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end else begin
          frame_set_c = 1'b1;
        end
      end
    end else if (bit_ev_c) begin
      tmo_n = '0;
      case (state_q)
        ST_DATA: begin
          shift_n   = {bit_c, shift_q[7:1]};
          bit_cnt_n = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_n   = bit_c;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (!bit_c)                    frame_set_c  = 1'b1;
          else if ((^shift_q) ^ par_q)   push_c       = 1'b1;
          else                           parity_set_c = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_n     = ST_IDLE;
      frame_set_c = 1'b1;
      tmo_n       = '0;
    end else begin
      tmo_n = tmo_q + TMO_W'(1);
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_n;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic              rda_q;
  logic [7:0]        data_q, data_n;
  logic              parity_err_q, frame_err_q, overflow_q;
  logic              pop_c, full_c, wr_en_c, ovf_set_c;

  // Pointer/occupancy update and the next show-ahead head value.
  always_comb begin
    pop_c     = bus.rd & rda_q;
    full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    wr_en_c   = push_c & (~full_c | pop_c);
    ovf_set_c = push_c & full_c & ~pop_c;
    rd_ptr_n  = rd_ptr_q + ADDR_W'(pop_c);
    wr_ptr_n  = wr_ptr_q + ADDR_W'(wr_en_c);
    count_n   = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
    data_n    = 8'hFF;
    if (count_n != '0) begin
      // The incoming byte lands directly at the head when the FIFO drains to it.
      if (wr_en_c && (wr_ptr_q == rd_ptr_n)) data_n = shift_q;
      else                                   data_n = mem_q[rd_ptr_n];
    end
  end

  // Storage array; a byte pushed alongside clear is discarded.
  always_ff @(posedge clk) begin
    if (wr_en_c && !bus.clear) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO control, registered outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      rda_q        <= 1'b0;
      data_q       <= 8'hFF;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (bus.clear) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      rda_q        <= 1'b0;
      data_q       <= 8'hFF;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_n;
      wr_ptr_q     <= wr_ptr_n;
      count_q      <= count_n;
      rda_q        <= (count_n != '0);
      data_q       <= data_n;
      parity_err_q <= parity_err_q | parity_set_c;
      frame_err_q  <= frame_err_q | frame_set_c;
      overflow_q   <= overflow_q | ovf_set_c;
    end
  end

  assign bus.rda        = rda_q;
  assign bus.data       = data_q;
  assign bus.count      = count_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised frame-level bench for ps2_rx_fifo against a queue-based reference model.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FL    = 8;
  localparam int TMO   = 1500;
  localparam int HALF  = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic kbd_clk = 1'b1;
  logic kbd_data = 1'b1;

  ps2_rx_fifo_if #(.ADDR_W(AW)) bus ();

  ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .kbd_clk(kbd_clk), .kbd_data(kbd_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes plus sticky flags.
  logic [7:0] mq[$];
  logic m_par = 1'b0;
  logic m_frm = 1'b0;
  logic m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_head();
    return (mq.size() > 0) ? mq[0] : 8'hFF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic compare_state(input string tag);
    check({tag, ".rda"},   32'(bus.rda),        32'(mq.size() > 0));
    check({tag, ".data"},  32'(bus.data),       32'(exp_head()));
    check({tag, ".count"}, 32'(bus.count),      32'(mq.size()));
    check({tag, ".perr"},  32'(bus.parity_err), 32'(m_par));
    check({tag, ".ferr"},  32'(bus.frame_err),  32'(m_frm));
    check({tag, ".ovf"},   32'(bus.overflow),   32'(m_ovf));
  endtask

  // One PS/2 bit: data set while the line clock is high, then a low half-period.
  // side: 0 none, 1 pulse rd on the receive cycle, 2 pulse clear on the receive cycle.
  task automatic send_bit(input logic b, input bit glitch, input int side);
    kbd_data = b;
    if (glitch) begin
      tick(5);
      kbd_clk = 1'b0;
      tick(FL - 2);
      kbd_clk = 1'b1;
      tick(HALF - 5 - (FL - 2));
    end else begin
      tick(HALF);
    end
    kbd_clk = 1'b0;
    if (side != 0) begin
      tick(FL + 1);
      if (side == 1) bus.rd = 1'b1; else bus.clear = 1'b1;
      tick(1);
      bus.rd = 1'b0;
      bus.clear = 1'b0;
      tick(HALF - FL - 2);
    end else begin
      tick(HALF);
    end
    kbd_clk = 1'b1;
  endtask

  // Full 11-bit frame plus the model's view of its outcome.
  task automatic send_frame(input logic [7:0] d, input bit par_bad, input logic stop_b,
                            input int glitch_bit, input int side);
    logic [10:0] fr;
    logic p;
    p  = par_bad ? (^d) : ~(^d);
    fr = {stop_b, p, d, 1'b0};
    for (int i = 0; i < 11; i++)
      send_bit(fr[i], i == glitch_bit, (i == 10) ? side : 0);
    tick(HALF);
    if (side == 2) begin
      model_reset();
    end else begin
      if (side == 1 && mq.size() > 0) void'(mq.pop_front());
      if (!stop_b)                m_frm = 1'b1;
      else if (par_bad)           m_par = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(d);
      else                        m_ovf = 1'b1;
    end
  endtask

  // Pop (or attempt to pop) one entry and check the head before and after.
  task automatic do_read(input string tag);
    check({tag, ".head"}, 32'(bus.data), 32'(exp_head()));
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    tick(1);
    compare_state(tag);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    model_reset();
    tick(1);
  endtask

  initial begin
    bus.clear = 1'b0;
    bus.rd    = 1'b0;
    #23;
    compare_state("reset");
    rst = 1'b1;
    tick(5);
    compare_state("idle");

    // Single good frame, then pop it.
    send_frame(8'h1C, 1'b0, 1'b1, -1, 0);
    compare_state("f1c");
    do_read("rd1c");

    // Bad parity, then a good frame keeps the sticky flag; clear wipes it.
    send_frame(8'h1C, 1'b1, 1'b1, -1, 0);
    compare_state("par_bad");
    send_frame(8'hF0, 1'b0, 1'b1, -1, 0);
    compare_state("f0");
    do_clear();
    compare_state("clr1");

    // Overflow when full, then drain in order.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, -1, 0);
    compare_state("full");
    for (int i = 0; i < 5; i++) do_read("drain");
    do_clear();

    // Pop on the same cycle as a push into a full FIFO.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, -1, 0);
    send_frame(8'h05, 1'b0, 1'b1, -1, 1);
    compare_state("full_pushpop");
    // Drain to one entry, then push and pop together.
    for (int i = 0; i < 3; i++) do_read("to_one");
    send_frame(8'h77, 1'b0, 1'b1, -1, 1);
    compare_state("one_pushpop");

    // Clear beats a simultaneous push.
    send_frame(8'h33, 1'b1, 1'b1, -1, 0);
    send_frame(8'h44, 1'b0, 1'b1, -1, 2);
    compare_state("clr_push");

    // Partial frame followed by inter-bit timeout.
    send_bit(1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 0);
    tick(TMO + FL + 20);
    m_frm = 1'b1;
    compare_state("timeout");
    send_frame(8'h5A, 1'b0, 1'b1, -1, 0);
    compare_state("after_tmo");
    do_clear();

    // Short clock glitch must not count as a bit; then a bad stop bit.
    send_frame(8'h3C, 1'b0, 1'b1, 4, 0);
    compare_state("glitch");
    send_frame(8'h81, 1'b0, 1'b0, -1, 0);
    compare_state("stop_bad");
    do_clear();

    // Asynchronous reset mid-frame with three entries queued.
    for (int i = 0; i < 3; i++) send_frame(8'(8'hA0 + i), 1'b0, 1'b1, -1, 0);
    compare_state("three");
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    #3 rst = 1'b0;
    model_reset();
    #1 compare_state("async_rst");
    @(posedge clk);
    #2 rst = 1'b1;
    tick(HALF);
    send_frame(8'h29, 1'b0, 1'b1, -1, 0);
    compare_state("after_rst");

    // Randomised frames with interleaved reads.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit pb;
      logic sb;
      int nr;
      d  = 8'($urandom);
      pb = ($urandom_range(0, 4) == 0);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(d, pb, sb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1, 0);
      compare_state("rnd");
      nr = $urandom_range(0, 2);
      for (int k = 0; k < nr; k++) do_read("rnd_rd");
      if ($urandom_range(0, 9) == 0) begin
        do_clear();
        compare_state("rnd_clr");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised next-generation PS/2 receiver (keyboard or mouse device-to-host path).
- Runs entirely on the system clock: kbd_clk/kbd_data are oversampled, synchronised and glitch-filtered rather than used as a clock.
- Validated frames are queued in a FIFO_DEPTH-entry scancode FIFO with a read-pop handshake, occupancy count and sticky error flags.
- Sits between the PS/2 pins and the peripheral interface register block.

Parameters:
FIFO_DEPTH, 8, scancode FIFO entries (power of two, >=2)
ADDR_W, 3, log2(FIFO_DEPTH)
FILTER_LEN, 8, consecutive identical samples needed to accept a kbd_clk level change (>=2)
TIMEOUT_CYCLES, 50000, idle clk cycles allowed between bits inside a frame before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush: empties FIFO, clears error flags, aborts the frame in progress
rd  in  1  pop head entry; ignored when rda=0
kbd_clk  in  1  raw PS/2 clock pin, asynchronous
kbd_data  in  1  raw PS/2 data pin, asynchronous
rda  out  1  FIFO non-empty
data  out  8  FIFO head (show-ahead); 8'hFF when empty
count  out  ADDR_W+1  entries held, 0..FIFO_DEPTH
parity_err  out  1  sticky: a frame failed odd parity
frame_err  out  1  sticky: bad start/stop bit or inter-bit timeout
overflow  out  1  sticky: a valid byte was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, async): FIFO empty, count=0, rda=0, data=8'hFF, all error flags 0, FSM=IDLE, filtered clock=1, sync flops=1.
- Input conditioning:
  - Two-flop synchronisers on kbd_clk and kbd_data.
  - Filtered clock level changes only after FILTER_LEN consecutive synced samples at the new level.
  - A bit event is a filtered 1->0 transition. On that cycle the bit value is the synced kbd_data.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: bit event with bit=0 -> DATA, bit counter=0. Bit event with bit=1 -> stay in IDLE, set frame_err.
  - DATA: shift bits in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: always returns to IDLE. If stop bit=1 and (^byte ^ parity bit)=1 (odd parity), push the byte. Stop bit=0 -> frame_err, no push. Parity wrong with stop bit good -> parity_err, no push.
  - Timeout: in DATA, PARITY or STOP, TIMEOUT_CYCLES clk cycles with no bit event -> IDLE, frame_err set, partial byte discarded. The timeout counter resets on every bit event and while in IDLE.
- Latency:
  - Push occurs on the clk edge after the stop-bit event cycle.
  - rda, data and count reflect the new entry on the same edge. That is 1 cycle after the event, plus synchroniser (2) and filter (FILTER_LEN) delay from the pin.
- Read:
  - rd=1 with rda=1 pops on that edge; data shows the next entry (or 8'hFF) after that edge.
  - rd with rda=0 has no effect.
- FIFO boundary conditions:
  - Push and pop in the same cycle: count unchanged. This holds when full (push accepted) and when count=1 (the new byte becomes the head).
  - Push when full without pop: byte dropped, overflow=1, FIFO contents and count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH.
- clear:
  - One cycle: FIFO emptied, count=0, data=8'hFF, flags=0, FSM->IDLE, timeout counter cleared.
  - clear beats a simultaneous push and a simultaneous rd; the byte is lost and no flag is set.
  - Synchronisers and filter are not affected by clear.
- Error flags are set-only until clear or reset. A flag setting in the same cycle as clear stays 0.
- Reset mid-frame: frame and FIFO fully discarded; the next start bit after reset release is received normally.

Test Plan:
- Single frame 0x1C (start 0, data LSB first, parity 0, stop 1), 10 kHz PS/2 clock -> rda=1, data=8'h1C, count=1; rd pulse -> rda=0, data=8'hFF, count=0.
- 0x1C sent with parity bit 1 -> no push, count=0, parity_err=1; then 0xF0 with parity 1 -> rda=1, data=8'hF0, parity_err still 1; clear -> all flags 0, count=0.
- FIFO_DEPTH=4: send 0x01..0x05 with no reads -> count=4, overflow=1. Four reads return 01,02,03,04, then rda=0. Also assert rd on the same cycle as the 5th push -> count stays 4, the head is 02 after the pop, and overflow stays 0.
- Five bits of a frame, then hold kbd_clk high for TIMEOUT_CYCLES+1 cycles -> frame_err=1, count=0. A following good 0x5A frame -> data=8'h5A.
- kbd_clk low glitch of FILTER_LEN-2 cycles in the middle of a frame -> no extra bit is counted and the frame is received correctly; stop bit forced to 0 -> frame_err=1, no push.
- rst low for one cycle mid-frame while count=3 -> count=0, rda=0, data=8'hFF immediately (async). The next full frame 0x29 is received correctly.
